// File: rtl/button_events.sv
// Turns a debounced button level into single-cycle press/release/click/double-click/long events.
// Define BUTTON_EVENTS_REPEAT_EN to add auto-repeat pulses (rep_o) while a long press is held.
module button_events #(
  parameter int LP = 1000,
  parameter int DC = 300,
  parameter int RP = 100,
  localparam int MAXP = (LP > DC) ? ((LP > RP) ? LP : RP) : ((DC > RP) ? DC : RP),
  localparam int CW = $clog2(MAXP + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic press_o,
  output logic release_o,
  output logic click_o,
  output logic dclick_o,
  output logic long_o,
  output logic rep_o
);

  typedef enum logic [2:0] {IDLE, PRESS1, WAIT2, PRESS2, LONG} state_t;

  localparam logic [CW-1:0] LP_LAST = CW'(LP - 1);
  localparam logic [CW-1:0] DC_LAST = CW'(DC - 1);
`ifdef BUTTON_EVENTS_REPEAT_EN
  localparam logic [CW-1:0] RP_LAST = CW'(RP - 1);
`endif

  state_t        state;
  logic          d_r;
  logic [CW-1:0] cnt;
  logic          pe, re;

  assign pe = d_i & ~d_r;
  assign re = ~d_i & d_r;

`ifndef BUTTON_EVENTS_REPEAT_EN
  assign rep_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      d_r       <= 1'b0;
      cnt       <= '0;
      press_o   <= 1'b0;
      release_o <= 1'b0;
      click_o   <= 1'b0;
      dclick_o  <= 1'b0;
      long_o    <= 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      rep_o     <= 1'b0;
`endif
    end else begin
      d_r       <= d_i;
      press_o   <= pe;
      release_o <= re;
      click_o   <= 1'b0;
      dclick_o  <= 1'b0;
      long_o    <= 1'b0;
`ifdef BUTTON_EVENTS_REPEAT_EN
      rep_o     <= 1'b0;
`endif
      // Edge events take priority over a timer boundary reached on the same cycle.
      case (state)
        IDLE: if (pe) begin
          state <= PRESS1;
          cnt   <= '0;
        end
        PRESS1: begin
          if (re) begin
            state <= WAIT2;
            cnt   <= '0;
          end else if (cnt == LP_LAST) begin
            long_o <= 1'b1;
            state  <= LONG;
            cnt    <= '0;
          end else cnt <= cnt + 1'b1;
        end
        WAIT2: begin
          if (pe) begin
            state <= PRESS2;
            cnt   <= '0;
          end else if (cnt == DC_LAST) begin
            click_o <= 1'b1;
            state   <= IDLE;
            cnt     <= '0;
          end else cnt <= cnt + 1'b1;
        end
        PRESS2: begin
          if (re) begin
            dclick_o <= 1'b1;
            state    <= IDLE;
            cnt      <= '0;
          end else if (cnt == LP_LAST) begin
            long_o <= 1'b1;
            state  <= LONG;
            cnt    <= '0;
          end else cnt <= cnt + 1'b1;
        end
        LONG: begin
          if (re) begin
            state <= IDLE;
            cnt   <= '0;
          end
`ifdef BUTTON_EVENTS_REPEAT_EN
          else if (cnt == RP_LAST) begin
            rep_o <= 1'b1;
            cnt   <= '0;
          end else cnt <= cnt + 1'b1;
`endif
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_events.sv
// Random and directed button waveforms checked against a timestamp-based gesture model.
module tb_button_events;
  localparam int LP = 8, DC = 6, RP = 4;

  logic clk = 1'b0, rst_n = 1'b0, d = 1'b0;
  logic press_o, release_o, click_o, dclick_o, long_o, rep_o;

  button_events #(.LP(LP), .DC(DC), .RP(RP)) dut (
    .clk(clk), .rst_n(rst_n), .d_i(d),
    .press_o(press_o), .release_o(release_o), .click_o(click_o),
    .dclick_o(dclick_o), .long_o(long_o), .rep_o(rep_o)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;

  task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%b want=%b (press,release,click,dclick,long,rep)", tag, $time, obs, exp);
    end
  endtask

  // Gesture model: timestamps of the current press and of the last short first-press release.
  int   t, p, lr;
  logic prev_d, pressed, second, elig;
  logic [5:0] exp_v;

  task automatic model_reset();
    t = 0; p = 0; lr = 0;
    prev_d = 0; pressed = 0; second = 0; elig = 0;
    exp_v = '0;
  endtask

  task automatic model_edge(input logic lvl);
    logic pr, rl, ck, dc, lg, rp;
    int held;
    t++;
    pr = 0; rl = 0; ck = 0; dc = 0; lg = 0; rp = 0;
    if (lvl && !prev_d) begin
      pr = 1;
      second = elig && (t - lr <= DC);
      elig = 0;
      pressed = 1;
      p = t;
    end else if (!lvl && elig && (t - lr == DC)) begin
      ck = 1;
      elig = 0;
    end
    if (!lvl && prev_d) begin
      rl = 1;
      held = t - p;
      pressed = 0;
      if (held <= LP) begin
        if (second) dc = 1;
        else begin
          elig = 1;
          lr = t;
        end
      end else elig = 0;
    end
    if (lvl && prev_d && pressed) begin
      held = t - p;
      if (held == LP) lg = 1;
`ifdef BUTTON_EVENTS_REPEAT_EN
      if (held > LP && (held - LP) % RP == 0) rp = 1;
`endif
    end
    prev_d = lvl;
    exp_v = {pr, rl, ck, dc, lg, rp};
  endtask

  function automatic logic [5:0] obs_v();
    return {press_o, release_o, click_o, dclick_o, long_o, rep_o};
  endfunction

  task automatic step();
    @(posedge clk);
    if (!rst_n) model_reset();
    else model_edge(d);
    #1 check(rst_n ? "edge" : "in_reset", obs_v(), exp_v);
  endtask

  task automatic drive(input logic lvl, input int n);
    d = lvl;
    repeat (n) step();
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    #1 check("async_reset", obs_v(), 6'b0);
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    repeat (2) step();
    rst_n = 1'b1;
    drive(0, 3);
    // single click, double click, long press
    drive(1, 3);  drive(0, 10);
    drive(1, 2);  drive(0, 3);  drive(1, 2);  drive(0, 10);
    drive(1, 12); drive(0, 10);
    // release exactly at the long threshold; second press exactly at the click boundary
    drive(1, 8);  drive(0, 10);
    drive(1, 3);  drive(0, 6);  drive(1, 3);  drive(0, 10);
    drive(1, 3);  drive(0, 5);  drive(1, 8);  drive(0, 10);
    // reset during PRESS1 with the button held
    drive(1, 4);  do_reset(2);  drive(1, 12); drive(0, 10);
    // repeat window, release on a repeat boundary
    drive(1, 20); drive(0, 10);
    drive(1, 21); drive(0, 10);
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 29) == 0) do_reset($urandom_range(1, 3));
      drive(1, $urandom_range(1, LP + 3 * RP + 2));
      drive(0, $urandom_range(1, DC + 3));
    end
    drive(0, 12);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
